// File: rtl/pe_sequencer.sv
// ---------------------------------------------------------------------------
// pe_sequencer
//
// Instruction-level controller for one 16-lane bit-serial PE block and its
// dual-port register BRAM. One macro-instruction is accepted at a time over a
// valid/ready handshake and expanded into per-cycle BRAM addresses, write
// enables, ALU select, cycle counter, neighbour-shift strobes and RAM-init
// control. Every output is registered.
//
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   instr_valid/ready   instruction handshake (ready high only when idle)
//   instr_kind          0=ALU 1=SHIFT 2=LOAD 3=reserved (NOP)
//   instr_dir           shift direction 0=E 1=W 2=N 3=S
//   instr_alu           ALU select
//   instr_src_a/b, dst  base BRAM rows
//   instr_length        word length (bits for ALU, rows for SHIFT/LOAD)
//   load_valid/ready    BRAM_IN word handshake during LOAD
//   op_in               AND-reduced OpStart from the PE block
//   addra, addrb        BRAM port addresses
//   wea, web            BRAM write enables
//   alu_sel             latched ALU select
//   count               cycle index inside the current instruction
//   east..south         shift-path select (one-hot or zero)
//   ram_init            selects BRAM_IN onto port A
//   state               0=IDLE 1=ALU 2=SHIFT 3=LOAD
//   done                one-cycle completion pulse
//   op_flag             op_in captured in the final ALU write cycle
// ---------------------------------------------------------------------------
module pe_sequencer #(
    parameter int MAX_WORD_LENGTH = 32,
    parameter int ADDR_W          = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [1:0]        instr_kind,
    input  logic [1:0]        instr_dir,
    input  logic [3:0]        instr_alu,
    input  logic [ADDR_W-1:0] instr_src_a,
    input  logic [ADDR_W-1:0] instr_src_b,
    input  logic [ADDR_W-1:0] instr_dst,
    input  logic [5:0]        instr_length,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic              op_in,
    output logic [ADDR_W-1:0] addra,
    output logic [ADDR_W-1:0] addrb,
    output logic              wea,
    output logic              web,
    output logic [3:0]        alu_sel,
    output logic [6:0]        count,
    output logic              east,
    output logic              west,
    output logic              north,
    output logic              south,
    output logic              ram_init,
    output logic [1:0]        state,
    output logic              done,
    output logic              op_flag
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALU   = 2'd1,
        S_SHIFT = 2'd2,
        S_LOAD  = 2'd3
    } state_t;

    localparam logic [5:0]        MAX_LEN  = 6'(MAX_WORD_LENGTH);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_reg;
    logic [ADDR_W-1:0] src_a_reg;
    logic [ADDR_W-1:0] src_b_reg;
    logic [ADDR_W-1:0] dst_reg;
    logic [1:0]        dir_reg;
    logic [5:0]        len_reg;
    logic [5:0]        idx_reg;     // LOAD words already scheduled

    logic [5:0]        len_clamped;
    logic [6:0]        count_inc;
    logic [5:0]        alu_k;
    logic [4:0]        pairs_m1;
    logic [ADDR_W-1:0] alu_off;
    logic [ADDR_W-1:0] shift_off;
    logic [ADDR_W-1:0] load_off;
    logic              last_cycle;

    assign state = state_reg;

    // Offsets are derived from the count value the next cycle will carry,
    // because the addresses are registered one edge ahead of use.
    always_comb begin
        len_clamped = (instr_length > MAX_LEN) ? MAX_LEN : instr_length;
        count_inc   = (count == 7'd127) ? 7'd127 : count + 7'd1;
        // (c-2)>>1 for c>=2, written so that no bit of count_inc is dropped
        alu_k       = count_inc[6:1] - 6'd1;
        alu_off     = {{(ADDR_W-6){1'b0}}, alu_k};
        // 2p where p = c>>2
        shift_off   = {{(ADDR_W-6){1'b0}}, count_inc[6:2], 1'b0};
        load_off    = {{(ADDR_W-6){1'b0}}, idx_reg};
        pairs_m1    = len_reg[5:1] - 5'd1;
        last_cycle  = 1'b0;
        case (state_reg)
            S_ALU:   last_cycle = (count == {len_reg, 1'b1});     // 2*len+1
            S_SHIFT: last_cycle = (count == {pairs_m1, 2'b11});   // 4*P-1
            S_LOAD:  last_cycle = (idx_reg == len_reg);
            default: last_cycle = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= S_IDLE;
            src_a_reg   <= '0;
            src_b_reg   <= '0;
            dst_reg     <= '0;
            dir_reg     <= '0;
            len_reg     <= '0;
            idx_reg     <= '0;
            instr_ready <= 1'b1;
            load_ready  <= 1'b0;
            addra       <= '0;
            addrb       <= '0;
            wea         <= 1'b0;
            web         <= 1'b0;
            alu_sel     <= '0;
            count       <= '0;
            east        <= 1'b0;
            west        <= 1'b0;
            north       <= 1'b0;
            south       <= 1'b0;
            ram_init    <= 1'b0;
            done        <= 1'b0;
            op_flag     <= 1'b0;
        end else begin
            // Pulsed outputs default low every cycle.
            done       <= 1'b0;
            wea        <= 1'b0;
            web        <= 1'b0;
            load_ready <= 1'b0;
            east       <= 1'b0;
            west       <= 1'b0;
            north      <= 1'b0;
            south      <= 1'b0;

            if (state_reg == S_IDLE) begin
                if (instr_valid) begin
                    src_a_reg <= instr_src_a;
                    src_b_reg <= instr_src_b;
                    dst_reg   <= instr_dst;
                    dir_reg   <= instr_dir;
                    len_reg   <= len_clamped;
                    alu_sel   <= instr_alu;
                    count     <= '0;
                    idx_reg   <= '0;
                    addra     <= instr_src_a;
                    addrb     <= instr_src_b;
                    case (instr_kind)
                        2'd0: begin
                            if (len_clamped != 6'd0) begin
                                state_reg   <= S_ALU;
                                instr_ready <= 1'b0;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                        2'd1: begin
                            if (len_clamped[5:1] != 5'd0) begin
                                state_reg   <= S_SHIFT;
                                instr_ready <= 1'b0;
                                addrb       <= instr_src_a + ADDR_ONE;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                        2'd2: begin
                            if (len_clamped != 6'd0) begin
                                state_reg   <= S_LOAD;
                                instr_ready <= 1'b0;
                                ram_init    <= 1'b1;
                                addra       <= instr_dst;
                                // A word offered on the accept edge is
                                // written in the first execution cycle.
                                if (load_valid) begin
                                    wea        <= 1'b1;
                                    load_ready <= 1'b1;
                                    idx_reg    <= 6'd1;
                                end
                            end else begin
                                done <= 1'b1;
                            end
                        end
                        default: done <= 1'b1;
                    endcase
                end
            end else if (last_cycle) begin
                state_reg   <= S_IDLE;
                instr_ready <= 1'b1;
                done        <= 1'b1;
                ram_init    <= 1'b0;
                if (state_reg == S_ALU) begin
                    op_flag <= op_in;
                end
            end else begin
                case (state_reg)
                    S_ALU: begin
                        count <= count_inc;
                        // count 1 holds the primed addresses
                        if (count_inc >= 7'd2) begin
                            if (count_inc[0]) begin
                                addra <= dst_reg + alu_off;
                                wea   <= 1'b1;
                            end else begin
                                addra <= src_a_reg + alu_off;
                                addrb <= src_b_reg + alu_off;
                            end
                        end
                    end
                    S_SHIFT: begin
                        count <= count_inc;
                        case (count_inc[1:0])
                            2'b00: begin
                                addra <= src_a_reg + shift_off;
                                addrb <= src_a_reg + shift_off + ADDR_ONE;
                            end
                            2'b10: begin
                                addra <= dst_reg + shift_off;
                                addrb <= dst_reg + shift_off + ADDR_ONE;
                                wea   <= 1'b1;
                                web   <= 1'b1;
                                east  <= (dir_reg == 2'd0);
                                west  <= (dir_reg == 2'd1);
                                north <= (dir_reg == 2'd2);
                                south <= (dir_reg == 2'd3);
                            end
                            default: ;
                        endcase
                    end
                    S_LOAD: begin
                        // count tracks the word index and holds on stalls
                        count <= {1'b0, idx_reg};
                        addra <= dst_reg + load_off;
                        if (load_valid) begin
                            wea        <= 1'b1;
                            load_ready <= 1'b1;
                            idx_reg    <= idx_reg + 6'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
